led_bank_scheduler: RTL
=======================

# led_bank_scheduler

Time-slicing scheduler that shares the board's 8-LED bank between up to NUM_SRC requesters on the LCMXO2 design. Each requester presents an 8-bit pattern and a request. The block grants the bank round-robin for a fixed dwell period and drives the registered winner's pattern onto D. It sits between the pattern generators (counters, status logic) and the LED pins.

## Interface

- NUM_SRC, 4: number of requesters, 2..8.
- DWELL_CYCLES, 12_000_000: CLK cycles per slot, ≥2; internal counter width is $clog2(DWELL_CYCLES).

Ports:

- CLK  in  1  system clock.
- RST  in  1  reset, asynchronous, active-high.
- REQ  in  NUM_SRC  per-source request, level.
- DATA  in  NUM_SRC*8  per-source pattern; source i at DATA[8i+7:8i].
- GRANT  out  NUM_SRC  one-hot owner of the bank; all-zero when idle.
- D  out  8  LED drive, registered.
- SLOT_DONE  out  1  one-cycle pulse when a slot ends.
- BUSY  out  1  high while in SHOW.

## Operation

- FSM has two states.
  - IDLE: GRANT=0, D=0x00, BUSY=0.
  - SHOW: bank owned by GRANT.
- Round-robin pointer LAST holds the last granted index. The search order is LAST+1, LAST+2, … mod NUM_SRC, with LAST itself last. The selected index is the first with REQ high.
- IDLE → SHOW when any REQ is high:
  - GRANT ← onehot(sel), LAST ← sel.
  - Dwell counter ← DWELL_CYCLES-1.
- In SHOW, D ← DATA[owner] every cycle, so pattern changes from the owner propagate with 1-cycle latency.
- A slot ends when either condition holds:
  - the counter is 0 (expiry), or
  - REQ[owner] is low (early release).
- On slot end:
  - SLOT_DONE=1 for one cycle.
  - If any REQ is high, the next owner is granted at the same edge with no gap cycle; a sole requester is re-granted to itself.
  - Otherwise → IDLE, and D=0x00 and GRANT=0 at that edge.
- Expiry and release in the same cycle give one SLOT_DONE.
- A REQ assertion by a non-owner never preempts the current slot.
- Counter decrements by 1 per cycle in SHOW. It never wraps: reload always occurs at 0.

## Timing

- RST asserted, at any time including mid-slot, immediately forces:
  - state=IDLE, GRANT=0, D=0x00, SLOT_DONE=0, BUSY=0.
  - LAST=NUM_SRC-1, so the first grant after reset searches from source 0.
  - counter=0.
  - PWM counter=0 (if compiled).
- RST deassertion is not synchronized internally; the board-level reset bridge guarantees it.
- REQ sampled high at edge k in IDLE → GRANT, BUSY and D valid after edge k.
- With REQ held, GRANT is stable for exactly DWELL_CYCLES cycles.
- SLOT_DONE is high during the cycle after the ending edge, coincident with the new GRANT.
- Early release: REQ[owner] low at edge k → handoff (or IDLE) at edge k.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration

- LED_PWM_EN defined:
  - Adds input BRIGHT, NUM_SRC*4 bits: 4-bit brightness per source.
  - Adds a free-running 4-bit PWM counter P.
  - D ← DATA[owner] & {8{P < BRIGHT[owner]}}.
  - BRIGHT=0 gives D dark; BRIGHT=15 gives 15/16 duty.
  - The P count does not restart on grant.
- LED_PWM_EN undefined: BRIGHT and P are absent, and D ← DATA[owner] unmodified.

## Test plan

All scenarios use NUM_SRC=4, DWELL_CYCLES=4.

- Reset mid-slot: REQ=0b0010, DATA1=0x3C, then RST pulsed during cycle 2 of the slot → GRANT=0, D=0x00, BUSY=0 before the next CLK edge. After release, GRANT=0b0010 one cycle later.
- Single source: REQ=0b0100, DATA2=0xA5 held → GRANT=0b0100, D=0xA5 continuously, SLOT_DONE every 4 cycles.
- Fairness: REQ=0b1111, DATAi=0x10+i from reset → GRANT sequence 0001, 0010, 0100, 1000, 0001, 4 cycles each; D follows 0x10..0x13.
- Early release: REQ=0b0011 with owner 0 dropping REQ[0] at slot cycle 2 → SLOT_DONE pulse and GRANT=0b0010 at that edge, with no idle cycle.
- Idle return: all REQ drop at expiry → GRANT=0, D=0x00, BUSY=0. A later REQ=0b0001 is granted after 1 cycle, with the search starting after LAST.
- LED_PWM_EN: REQ=0b0001, DATA0=0xFF, BRIGHT0=4 → D=0xFF for exactly 4 of every 16 cycles, 0x00 otherwise.

Source files
------------

// File: rtl/led_bank_scheduler.sv
// led_bank_scheduler: round-robin time-slicing of the 8-LED bank between
// NUM_SRC requesters. Each grant lasts DWELL_CYCLES clocks, or less if the
// owner drops its request. All outputs are registered.
// Optional feature macro: LED_PWM_EN (adds per-source 4-bit brightness).
module led_bank_scheduler #(
    parameter int unsigned NUM_SRC      = 4,
    parameter int unsigned DWELL_CYCLES = 12_000_000
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NUM_SRC-1:0]   REQ,
    input  logic [NUM_SRC*8-1:0] DATA,
`ifdef LED_PWM_EN
    input  logic [NUM_SRC*4-1:0] BRIGHT,
`endif
    output logic [NUM_SRC-1:0]   GRANT,
    output logic [7:0]           D,
    output logic                 SLOT_DONE,
    output logic                 BUSY
);

    localparam int unsigned IDXW = $clog2(NUM_SRC);
    localparam int unsigned CNTW = $clog2(DWELL_CYCLES);
    localparam logic [IDXW:0]   NSRC_W   = (IDXW+1)'(NUM_SRC);
    localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(DWELL_CYCLES - 1);
    localparam logic [IDXW-1:0] LAST_RST = IDXW'(NUM_SRC - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [IDXW-1:0]     last_q, last_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic [NUM_SRC-1:0]  grant_q, grant_d;
    logic [7:0]          led_q, led_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;

    logic [7:0]          data_arr [NUM_SRC];
    logic [IDXW-1:0]     sel_c;
    logic [IDXW:0]       cand_c;
    logic                any_req_c;
    logic                owner_req_c;
    logic [7:0]          pat_own_c;
    logic [7:0]          pat_sel_c;

    // Split the flat pattern bus into per-source bytes
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_data
        assign data_arr[i] = DATA[8*i +: 8];
    end

`ifdef LED_PWM_EN
    logic [3:0] bright_arr [NUM_SRC];
    logic [3:0] pwm_q;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_bright
        assign bright_arr[i] = BRIGHT[4*i +: 4];
    end

    // Free-running PWM phase; deliberately not restarted on grant
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pwm_q <= 4'd0;
        end else begin
            pwm_q <= pwm_q + 4'd1;
        end
    end

    assign pat_own_c = data_arr[last_q] & {8{pwm_q < bright_arr[last_q]}};
    assign pat_sel_c = data_arr[sel_c]  & {8{pwm_q < bright_arr[sel_c]}};
`else
    assign pat_own_c = data_arr[last_q];
    assign pat_sel_c = data_arr[sel_c];
`endif

    assign any_req_c   = |REQ;
    assign owner_req_c = REQ[last_q];

    // Round-robin search from last+1 wrapping to last; nearest requester wins
    always_comb begin
        sel_c  = last_q;
        cand_c = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            cand_c = {1'b0, last_q} + (IDXW+1)'(k);
            if (cand_c >= NSRC_W) begin
                cand_c = cand_c - NSRC_W;
            end
            if (REQ[cand_c[IDXW-1:0]]) begin
                sel_c = cand_c[IDXW-1:0];
            end
        end
    end

    // State and output registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
            grant_q <= '0;
            led_q   <= 8'h00;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            led_q   <= led_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state: grant, dwell countdown, early release and handoff
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        led_d   = led_q;
        done_d  = 1'b0;
        busy_d  = busy_q;

        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                led_d   = 8'h00;
                busy_d  = 1'b0;
                if (any_req_c) begin
                    state_d = ST_SHOW;
                    last_d  = sel_c;
                    cnt_d   = CNT_LOAD;
                    grant_d = NUM_SRC'(1) << sel_c;
                    led_d   = pat_sel_c;
                    busy_d  = 1'b1;
                end
            end
            ST_SHOW: begin
                if ((cnt_q == '0) || !owner_req_c) begin
                    done_d = 1'b1;
                    if (any_req_c) begin
                        last_d  = sel_c;
                        cnt_d   = CNT_LOAD;
                        grant_d = NUM_SRC'(1) << sel_c;
                        led_d   = pat_sel_c;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        led_d   = 8'h00;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                    led_d = pat_own_c;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign GRANT     = grant_q;
    assign D         = led_q;
    assign SLOT_DONE = done_q;
    assign BUSY      = busy_q;

endmodule
